pool_storage_ctrl: RTL and testbench
====================================

Name: pool_storage_ctrl

Overview:
Sequencer for the 3x3x3 pooled-feature storage register, which holds 3 channels x 9 positions of 8-bit results. It accepts 2x2 max-pool results from the pool unit with a valid/ready handshake and generates the storage write strobe and position index (0..8). Once all 9 positions are written, it presents the complete vector to the downstream fully-connected stage with a valid/ready handshake. It back-pressures the pool unit while a full vector has not been consumed, and supports a synchronous flush of a partial vector.

Parameters:
NUM_POS, 9, positions per channel written per vector (3x3 map)
CNT_W, 4, width of position index; must satisfy 2^CNT_W >= NUM_POS
FRM_W, 16, width of completed-vector counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
pool_vld  input  1  pool unit has one 3-channel result this cycle
pool_rdy  output  1  controller accepts result this cycle
flush  input  1  synchronous abort of partial vector
store_vld  output  1  write strobe to storage (in_vld)
store_cnt  output  CNT_W  position index to storage (cnt)
lin_vld  output  1  full vector present on storage output
lin_rdy  input  1  downstream consumes vector
frame_done  output  1  one-cycle pulse on vector handoff
frame_cnt  output  FRM_W  count of vectors handed off, wraps
busy  output  1  at least one position written, vector not yet handed off

Behaviour:
- Reset (async, rst=1): state FILL, pos counter 0, lin_vld 0, frame_done 0, frame_cnt 0, busy 0. pool_rdy, store_vld are forced 0 while rst=1.
- States: FILL (collecting positions), FULL (vector complete, awaiting consumer). There is no separate idle state; FILL with pos=0 is idle.
- pool_rdy (combinational) = (state==FILL) | (state==FULL & lin_rdy), gated with !flush.
- accept = pool_vld & pool_rdy.
- store_vld = accept, combinational and same cycle. store_cnt = registered pos counter. This gives zero-latency write: storage captures data at the same edge.
- FILL:
  - On accept with pos < NUM_POS-1: pos increments.
  - On accept with pos == NUM_POS-1: pos goes to 0, state goes to FULL, lin_vld goes to 1 at next cycle.
- FULL: lin_vld=1, and the pos counter holds 0.
  - On lin_rdy: frame_done pulses 1 next cycle, frame_cnt increments (wraps at 2^FRM_W), lin_vld drops.
  - If lin_rdy=1 without accept, state goes to FILL.
  - Simultaneous lin_rdy and pool_vld: the handoff completes and the result is written to position 0 at the same edge. Downstream samples the pre-edge vector. pos goes to 1 and state goes to FILL.
- busy = (pos != 0) | (state==FULL).
- flush (FILL): pos goes to 0 and no write occurs. Stored bytes are not cleared, and the next vector overwrites them.
- flush (FULL): lin_vld drops, state goes to FILL, and neither frame_done nor frame_cnt changes. Flush has priority over lin_rdy and pool_vld.
- pool_vld while pool_rdy=0: no write and no state change. Upstream must hold its data (standard valid/ready).
- lin_vld, once asserted, stays high until lin_rdy or flush; it never deasserts otherwise.
- Reset mid-vector: all state returns to reset values immediately. The storage contents are owned by the storage block's own reset.
- pos never exceeds NUM_POS-1; the values NUM_POS..2^CNT_W-1 are unreachable.

Test Plan:
1. Reset, then 9 back-to-back pool_vld, lin_rdy=0 -> store_cnt 0..8 with store_vld each cycle; lin_vld=1 the cycle after the 9th; pool_rdy=0; busy=1.
2. From scenario 1 end, hold pool_vld=1 and assert lin_rdy for 1 cycle -> frame_done pulse, frame_cnt=1, store_vld=1 with store_cnt=0 at the same edge, next store_cnt=1, lin_vld=0.
3. Random pool_vld gaps (e.g. 1 valid per 3 cycles) -> exactly 9 store_vld per vector, indices strictly 0..8 in order, no write while pool_vld=0.
4. 5 accepts, then flush -> pos=0, busy=0, no store_vld in the flush cycle; the next accept writes store_cnt=0; completion needs 9 more accepts.
5. In FULL, flush together with lin_rdy=1 -> lin_vld=0, frame_done=0, frame_cnt unchanged, state FILL.
6. Assert rst asynchronously mid-vector (pos=6) and in FULL -> outputs go to reset values without a clock edge; after release, 9 accepts are needed for lin_vld; frame_cnt wraps from 65535 to 0 with FRM_W=16 preloaded by running 65536 vectors or by a forced counter.

Source files
------------

// File: rtl/pool_storage_ctrl_if.sv
// Handshake and storage-control bundle for the pooled-feature storage sequencer.
// The slave modport is the controller; the master modport is its environment.
interface pool_storage_ctrl_if #(
    parameter int CNT_W = 4,
    parameter int FRM_W = 16
);
    logic             pool_vld;
    logic             pool_rdy;
    logic             flush;
    logic             store_vld;
    logic [CNT_W-1:0] store_cnt;
    logic             lin_vld;
    logic             lin_rdy;
    logic             frame_done;
    logic [FRM_W-1:0] frame_cnt;
    logic             busy;

    modport master (
        output pool_vld, flush, lin_rdy,
        input  pool_rdy, store_vld, store_cnt, lin_vld, frame_done, frame_cnt, busy
    );

    modport slave (
        input  pool_vld, flush, lin_rdy,
        output pool_rdy, store_vld, store_cnt, lin_vld, frame_done, frame_cnt, busy
    );
endinterface

// File: rtl/pool_storage_ctrl.sv
// Sequencer for the 3-channel x 9-position pooled-feature storage register.
// Collects pool results into positions 0..NUM_POS-1 (zero-latency write strobe),
// then holds the full vector for the FC stage until it is consumed or flushed.
module pool_storage_ctrl #(
    parameter int NUM_POS = 9,
    parameter int CNT_W   = 4,
    parameter int FRM_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    pool_storage_ctrl_if.slave  bus
);
    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(NUM_POS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_pos;
    logic             r_lin_vld;
    logic             r_frame_done;
    logic [FRM_W-1:0] r_frame_cnt;

    logic w_pool_rdy;
    logic w_accept;

    // Ready while filling, or while full if the consumer frees the vector this
    // cycle; flush and reset both block acceptance.
    assign w_pool_rdy = !rst && !bus.flush && ((r_state == S_FILL) || bus.lin_rdy);
    assign w_accept   = bus.pool_vld && w_pool_rdy;

    assign bus.pool_rdy   = w_pool_rdy;
    assign bus.store_vld  = w_accept;
    assign bus.store_cnt  = r_pos;
    assign bus.lin_vld    = r_lin_vld;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.busy       = (r_pos != '0) || (r_state == S_FULL);

    // Fill/full sequencer with position counter, handoff pulse and vector count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FILL;
            r_pos        <= '0;
            r_lin_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.flush) begin
                // Abort: stored bytes are left in place and simply overwritten later.
                r_state   <= S_FILL;
                r_pos     <= '0;
                r_lin_vld <= 1'b0;
            end else begin
                case (r_state)
                    S_FILL: begin
                        if (w_accept) begin
                            if (r_pos == LAST_POS) begin
                                r_pos     <= '0;
                                r_state   <= S_FULL;
                                r_lin_vld <= 1'b1;
                            end else begin
                                r_pos <= r_pos + 1'b1;
                            end
                        end
                    end
                    S_FULL: begin
                        if (bus.lin_rdy) begin
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 1'b1;
                            r_lin_vld    <= 1'b0;
                            r_state      <= S_FILL;
                            // A result accepted during handoff lands in position 0.
                            r_pos        <= w_accept ? CNT_W'(1) : '0;
                        end
                    end
                    default: begin
                        r_state <= S_FILL;
                        r_pos   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pool_storage_ctrl.sv
// Self-checking bench for pool_storage_ctrl: table-driven opening sequence,
// hand-written corner cases, then randomized traffic against a vector-level model.
module tb_pool_storage_ctrl;
    localparam int NUM_POS = 9;
    localparam int CNT_W   = 4;
    localparam int FRM_W   = 16;

    logic clk;
    logic rst;

    pool_storage_ctrl_if #(.CNT_W(CNT_W), .FRM_W(FRM_W)) bus ();
    pool_storage_ctrl_if #(.CNT_W(CNT_W), .FRM_W(2))     bus_s ();

    pool_storage_ctrl #(.NUM_POS(NUM_POS), .CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow vector counter instance, used to observe wraparound quickly.
    pool_storage_ctrl #(.NUM_POS(NUM_POS), .CNT_W(CNT_W), .FRM_W(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.pool_vld = bus.pool_vld;
    assign bus_s.flush    = bus.flush;
    assign bus_s.lin_rdy  = bus.lin_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: number of results held in the current vector, whether a
    // complete vector is waiting, and how many vectors have been handed off.
    int m_n      = 0;
    bit m_full   = 0;
    bit m_done   = 0;
    int m_frames = 0;

    typedef struct {
        bit pv, fl, lr;
        bit rdy, svld;
        int cnt;
        bit lin, busy, done;
        int fcnt;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_n = 0; m_full = 0; m_done = 0; m_frames = 0;
    endtask

    task automatic compare_model(input bit pv, input bit fl, input bit lr);
        bit e_rdy;
        e_rdy = !fl && (!m_full || lr);
        chk("pool_rdy",   int'(bus.pool_rdy),   int'(e_rdy));
        chk("store_vld",  int'(bus.store_vld),  int'(pv && e_rdy));
        chk("store_cnt",  int'(bus.store_cnt),  m_full ? 0 : m_n);
        chk("lin_vld",    int'(bus.lin_vld),    int'(m_full));
        chk("busy",       int'(bus.busy),       int'(m_full || m_n != 0));
        chk("frame_done", int'(bus.frame_done), int'(m_done));
        chk("frame_cnt",  int'(bus.frame_cnt),  m_frames % 65536);
        chk("frame_cnt_narrow", int'(bus_s.frame_cnt), m_frames % 4);
    endtask

    task automatic model_update(input bit pv, input bit fl, input bit lr);
        bit acc;
        acc = pv && !fl && (!m_full || lr);
        m_done = 0;
        if (fl) begin
            m_n = 0;
            m_full = 0;
        end else if (m_full) begin
            if (lr) begin
                m_done = 1;
                m_frames++;
                m_full = 0;
                m_n = acc ? 1 : 0;
            end
        end else if (acc) begin
            m_n++;
            if (m_n == NUM_POS) begin
                m_n = 0;
                m_full = 1;
            end
        end
    endtask

    // One clock: drive at negedge, compare #1 later, update model at posedge.
    task automatic step(input bit pv, input bit fl, input bit lr);
        bus.pool_vld = pv; bus.flush = fl; bus.lin_rdy = lr;
        #1;
        compare_model(pv, fl, lr);
        @(posedge clk);
        model_update(pv, fl, lr);
        @(negedge clk);
    endtask

    task automatic check_row(input int i);
        bus.pool_vld = tbl[i].pv; bus.flush = tbl[i].fl; bus.lin_rdy = tbl[i].lr;
        #1;
        chk("tbl_pool_rdy",   int'(bus.pool_rdy),   int'(tbl[i].rdy));
        chk("tbl_store_vld",  int'(bus.store_vld),  int'(tbl[i].svld));
        chk("tbl_store_cnt",  int'(bus.store_cnt),  tbl[i].cnt);
        chk("tbl_lin_vld",    int'(bus.lin_vld),    int'(tbl[i].lin));
        chk("tbl_busy",       int'(bus.busy),       int'(tbl[i].busy));
        chk("tbl_frame_done", int'(bus.frame_done), int'(tbl[i].done));
        chk("tbl_frame_cnt",  int'(bus.frame_cnt),  tbl[i].fcnt);
        @(posedge clk);
        model_update(tbl[i].pv, tbl[i].fl, tbl[i].lr);
        @(negedge clk);
    endtask

    // Assert reset between clock edges and check outputs before any edge occurs.
    task automatic async_reset(input string tag);
        bus.pool_vld = 1'b1; bus.flush = 1'b0; bus.lin_rdy = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk({tag, "_pool_rdy"},   int'(bus.pool_rdy),   0);
        chk({tag, "_store_vld"},  int'(bus.store_vld),  0);
        chk({tag, "_store_cnt"},  int'(bus.store_cnt),  0);
        chk({tag, "_lin_vld"},    int'(bus.lin_vld),    0);
        chk({tag, "_busy"},       int'(bus.busy),       0);
        chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
        chk({tag, "_frame_cnt"},  int'(bus.frame_cnt),  0);
        #1;
        rst = 1'b0;
        model_clear();
        bus.pool_vld = 1'b0; bus.lin_rdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int saved_fcnt;
        bus.pool_vld = 1'b0; bus.flush = 1'b0; bus.lin_rdy = 1'b0;
        rst = 1'b1;

        // Opening sequence: 9 back-to-back accepts, wait in FULL, then a
        // handoff with a simultaneous write to position 0.
        for (int i = 0; i < 9; i++)
            tbl[i] = '{pv:1, fl:0, lr:0, rdy:1, svld:1, cnt:i, lin:0,
                       busy:(i != 0), done:0, fcnt:0};
        tbl[9]  = '{pv:0, fl:0, lr:0, rdy:0, svld:0, cnt:0, lin:1, busy:1, done:0, fcnt:0};
        tbl[10] = '{pv:1, fl:0, lr:1, rdy:1, svld:1, cnt:0, lin:1, busy:1, done:0, fcnt:0};
        tbl[11] = '{pv:0, fl:0, lr:0, rdy:1, svld:0, cnt:1, lin:0, busy:1, done:1, fcnt:1};

        #3;
        chk("rst_pool_rdy", int'(bus.pool_rdy), 0);
        chk("rst_lin_vld",  int'(bus.lin_vld),  0);
        chk("rst_busy",     int'(bus.busy),     0);
        chk("rst_frame_cnt", int'(bus.frame_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        for (int i = 0; i < 12; i++) check_row(i);

        // Partial vector flush: 5 accepts then flush with pool_vld held high.
        async_reset("rst0");
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        bus.pool_vld = 1'b1; bus.flush = 1'b1; bus.lin_rdy = 1'b0;
        #1;
        chk("flush_store_vld", int'(bus.store_vld), 0);
        chk("flush_pool_rdy",  int'(bus.pool_rdy),  0);
        @(posedge clk); model_update(1, 1, 0); @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("post_flush_busy", int'(bus.busy),      0);
        chk("post_flush_cnt",  int'(bus.store_cnt), 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        chk("flush_8_lin", int'(bus.lin_vld), 0);
        step(1, 0, 0);
        chk("flush_9_lin", int'(bus.lin_vld), 1);

        // Flush in FULL beats lin_rdy and pool_vld.
        saved_fcnt = int'(bus.frame_cnt);
        step(1, 1, 1);
        chk("fullflush_lin",  int'(bus.lin_vld),    0);
        chk("fullflush_done", int'(bus.frame_done), 0);
        chk("fullflush_fcnt", int'(bus.frame_cnt),  saved_fcnt);
        chk("fullflush_busy", int'(bus.busy),       0);
        step(0, 0, 0);

        // Reset mid-vector at position 6.
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        chk("pre_rst_cnt", int'(bus.store_cnt), 6);
        async_reset("rst_mid");
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        chk("rst_mid_8_lin", int'(bus.lin_vld), 0);
        step(1, 0, 0);
        chk("rst_mid_9_lin", int'(bus.lin_vld), 1);

        // Reset while FULL.
        async_reset("rst_full");

        // Narrow counter wraps after four handoffs.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 9; i++) step(1, 0, 0);
            step(0, 0, 1);
        end
        chk("wrap_narrow", int'(bus_s.frame_cnt), 0);
        chk("wrap_wide",   int'(bus.frame_cnt),   4);

        // Randomized traffic: sparse valids, random consumer, rare flushes.
        for (int c = 0; c < 3000; c++) begin
            bit pv, fl, lr;
            pv = ($urandom_range(0, 2) == 0);
            lr = ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 63) == 0);
            step(pv, fl, lr);
        end
        chk("rand_frames_seen", int'(m_frames > 10), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
